inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl.sv | 127 ++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_ctrl
// Purpose  : Single-line instruction fetch buffer. A hit returns the word
//            combinationally; a miss stalls the pipeline while the whole line
//            is refilled word by word from backing memory.
// Revision : 1.0  initial release
// ============================================================================
module inst_fetch_ctrl #(
  parameter int LINE_WORDS = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ce,
  input  logic [31:0] addr,
  output logic [31:0] inst,
  output logic        stallreq,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int IDXW = $clog2(LINE_WORDS);
  localparam int TAGW = 30 - IDXW;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic [TAGW-1:0]   ftag_q, ftag_d;
  logic [31:0]       buf_q [LINE_WORDS];

  logic [TAGW-1:0]   addr_tag;
  logic [IDXW-1:0]   addr_idx;
  logic              hit;
  logic              fill_we;

  assign addr_tag = addr[31:2+IDXW];
  assign addr_idx = addr[1+IDXW:2];
  assign hit      = ce && valid_q && (addr_tag == tag_q) && (state_q == S_IDLE);
  assign fill_we  = (state_q == S_FILL) && mem_ack;

  // Control state register; buffer contents are deliberately left unreset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      ftag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      ftag_q  <= ftag_d;
    end
  end

  // One write port per buffer word, selected by the fill counter.
  generate
    for (genvar i = 0; i < LINE_WORDS; i++) begin : g_word
      always_ff @(posedge Clk) begin
        if (fill_we && (cnt_q == IDXW'(i))) begin
          buf_q[i] <= mem_rdata;
        end
      end
    end
  endgenerate

  // Next-state logic: start a fill on a miss, count acks, close out the line.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    ftag_d  = ftag_q;
    case (state_q)
      S_IDLE: begin
        if (ce && !hit) begin
          state_d = S_FILL;
          ftag_d  = addr_tag;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      S_FILL: begin
        if (mem_ack) begin
          // Counter is exactly IDXW wide, so the final increment wraps to 0.
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == IDXW'(LINE_WORDS - 1)) begin
            state_d = S_IDLE;
            valid_d = 1'b1;
            tag_d   = ftag_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: zero-latency hit path, stall on anything else while enabled.
  always_comb begin
    inst     = 32'h0;
    stallreq = 1'b0;
    mem_req  = 1'b0;
    mem_addr = 32'h0;
    if (hit) begin
      inst = buf_q[addr_idx];
    end
    if (ce && !hit) begin
      stallreq = 1'b1;
    end
    if (state_q == S_FILL) begin
      mem_req  = 1'b1;
      mem_addr = {ftag_q, cnt_q, 2'b00};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_ctrl
// Purpose  : Self-checking bench for inst_fetch_ctrl with LINE_WORDS = 4.
// Revision : 1.0  initial release
// ============================================================================
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        stallreq;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  inst_fetch_ctrl #(.LINE_WORDS(4)) dut (
    .Clk       (clk),
    .Rst       (rst),
    .ce        (ce),
    .addr      (addr),
    .inst      (inst),
    .stallreq  (stallreq),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] e_inst;
    logic        e_stall;
    logic        e_req;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_vec  = 0;

  function automatic vec_t mk(logic r, logic c, logic [31:0] a, logic k,
                              logic [31:0] d, logic [31:0] ei, logic es,
                              logic er, logic [31:0] em);
    vec_t v;
    v.rst = r; v.ce = c; v.addr = a; v.ack = k; v.rdata = d;
    v.e_inst = ei; v.e_stall = es; v.e_req = er; v.e_maddr = em;
    return v;
  endfunction

  // Drive one cycle of stimulus just after the rising edge, queue its expectation.
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst       = v.rst;
    ce        = v.ce;
    addr      = v.addr;
    mem_ack   = v.ack;
    mem_rdata = v.rdata;
    sb.push_back(v);
  endtask

  // Shorthand for a normal (non-reset) cycle.
  task automatic cyc(input logic c, input logic [31:0] a, input logic k,
                     input logic [31:0] d, input logic [31:0] ei, input logic es,
                     input logic er, input logic [31:0] em);
    apply(mk(1'b0, c, a, k, d, ei, es, er, em));
  endtask

  // Compare DUT outputs on the falling edge against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      n_cmp += 4;
      if (inst !== e.e_inst) begin
        n_fail++;
        $display("FAIL inst vec %0d: got %h want %h", n_vec, inst, e.e_inst);
      end
      if (stallreq !== e.e_stall) begin
        n_fail++;
        $display("FAIL stallreq vec %0d: got %b want %b", n_vec, stallreq, e.e_stall);
      end
      if (mem_req !== e.e_req) begin
        n_fail++;
        $display("FAIL mem_req vec %0d: got %b want %b", n_vec, mem_req, e.e_req);
      end
      if (mem_addr !== e.e_maddr) begin
        n_fail++;
        $display("FAIL mem_addr vec %0d: got %h want %h", n_vec, mem_addr, e.e_maddr);
      end
      n_vec++;
    end
  end

  initial begin
    rst = 1'b1; ce = 1'b0; addr = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);

    // Reset state, cold miss of line 0, hit sweep, ce-low and idle-ack checks.
    //             rst   ce    addr          ack   rdata         inst          st    req   maddr
    tbl.push_back(mk(1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h00));
    tbl.push_back(mk(1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h00));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h00));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'h11,       32'h0,        1'b1, 1'b1, 32'h00));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'h22,       32'h0,        1'b1, 1'b1, 32'h04));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'h33,       32'h0,        1'b1, 1'b1, 32'h08));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'h44,       32'h0,        1'b1, 1'b1, 32'h0C));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0,        32'h11,       1'b0, 1'b0, 32'h00));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'h0,        32'h22,       1'b0, 1'b0, 32'h00));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0008, 1'b0, 32'h0,        32'h33,       1'b0, 1'b0, 32'h00));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_000C, 1'b0, 32'h0,        32'h44,       1'b0, 1'b0, 32'h00));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0007, 1'b0, 32'h0,        32'h22,       1'b0, 1'b0, 32'h00));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0000_0008, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h00));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 32'h0,       1'b0, 1'b0, 32'h00));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0,        32'h11,       1'b0, 1'b0, 32'h00));
    foreach (tbl[i]) apply(tbl[i]);

    // Tag miss on line 0x10 with an ack every third cycle.
    cyc(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int w = 0; w < 4; w++) begin
      cyc(1'b1, 32'h10, 1'b0, 32'h0,            32'h0, 1'b1, 1'b1, 32'h10 + 32'(4*w));
      cyc(1'b1, 32'h10, 1'b0, 32'h0,            32'h0, 1'b1, 1'b1, 32'h10 + 32'(4*w));
      cyc(1'b1, 32'h10, 1'b1, 32'hA0 + 32'(w),  32'h0, 1'b1, 1'b1, 32'h10 + 32'(4*w));
    end
    for (int w = 0; w < 4; w++)
      cyc(1'b1, 32'h10 + 32'(4*w), 1'b0, 32'h0, 32'hA0 + 32'(w), 1'b0, 1'b0, 32'h0);

    // Address change mid-fill: line 0x20 completes before 0x40 is fetched.
    cyc(1'b1, 32'h20, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 32'h00);
    cyc(1'b1, 32'h20, 1'b1, 32'hB0, 32'h0, 1'b1, 1'b1, 32'h20);
    cyc(1'b1, 32'h20, 1'b1, 32'hB1, 32'h0, 1'b1, 1'b1, 32'h24);
    cyc(1'b1, 32'h40, 1'b0, 32'h0,  32'h0, 1'b1, 1'b1, 32'h28);
    cyc(1'b1, 32'h40, 1'b1, 32'hB2, 32'h0, 1'b1, 1'b1, 32'h28);
    cyc(1'b1, 32'h40, 1'b1, 32'hB3, 32'h0, 1'b1, 1'b1, 32'h2C);
    cyc(1'b1, 32'h40, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 32'h00);
    for (int w = 0; w < 4; w++)
      cyc(1'b1, 32'h40, 1'b1, 32'hC0 + 32'(w), 32'h0, 1'b1, 1'b1, 32'h40 + 32'(4*w));
    cyc(1'b1, 32'h40, 1'b0, 32'h0, 32'hC0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 32'h4C, 1'b0, 32'h0, 32'hC3, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 32'h44, 1'b0, 32'h0, 32'hC1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 32'h20, 1'b0, 32'h0, 32'h0,  1'b0, 1'b0, 32'h0);

    // Reset mid-fill of line 0x60, stray ack afterwards, then a full refill.
    cyc(1'b1, 32'h60, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 32'h00);
    cyc(1'b1, 32'h60, 1'b1, 32'hD0, 32'h0, 1'b1, 1'b1, 32'h60);
    cyc(1'b1, 32'h60, 1'b1, 32'hD1, 32'h0, 1'b1, 1'b1, 32'h64);
    apply(mk(1'b1, 1'b1, 32'h60, 1'b1, 32'hD2, 32'h0, 1'b1, 1'b1, 32'h68));
    cyc(1'b0, 32'h60, 1'b1, 32'hEE, 32'h0, 1'b0, 1'b0, 32'h00);
    cyc(1'b1, 32'h60, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 32'h00);
    for (int w = 0; w < 4; w++)
      cyc(1'b1, 32'h60, 1'b1, 32'hE0 + 32'(w), 32'h0, 1'b1, 1'b1, 32'h60 + 32'(4*w));
    cyc(1'b1, 32'h60, 1'b0, 32'h0, 32'hE0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 32'h68, 1'b0, 32'h0, 32'hE2, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 32'h64, 1'b0, 32'h0, 32'hE1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 32'h64, 1'b0, 32'h0, 32'h0,  1'b0, 1'b0, 32'h0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
